// File: rtl/lyra2_batch_scheduler.sv
// Lyra2 batch scheduler: moves PIPELINE_DEPTH-hash batches from the input FIFO through the core into the output FIFO.
// Optional macro LYRA2_SCHED_STATS_EN adds saturating busy/stall cycle counters.
module lyra2_batch_scheduler #(
  parameter int PIPELINE_DEPTH = 8,
  parameter int DATA_WIDTH     = 256,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_fifo_almost_empty,
  input  logic                  in_fifo_empty,
  input  logic [DATA_WIDTH-1:0] in_fifo_dout,
  output logic                  in_fifo_rd_en,
  output logic                  core_in_valid,
  output logic                  core_in_first,
  output logic [DATA_WIDTH-1:0] core_in_data,
  input  logic                  core_out_valid,
  input  logic [DATA_WIDTH-1:0] core_out_data,
  input  logic                  out_fifo_almost_full,
  output logic                  out_fifo_wr_en,
  output logic [DATA_WIDTH-1:0] out_fifo_din,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  batch_cnt,
  output logic                  err_unexpected
`ifdef LYRA2_SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_busy_cycles,
  output logic [CNT_WIDTH-1:0]  stat_stall_cycles
`endif
);

  localparam int IW = $clog2(PIPELINE_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         issue_q, issue_d;
  logic [IW-1:0]         ret_q, ret_d;
  logic [CNT_WIDTH-1:0]  batch_q, batch_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  always_comb begin
    state_d       = state_q;
    issue_d       = issue_q;
    ret_d         = ret_q;
    batch_d       = batch_q;
    err_d         = err_q;
    wr_d          = 1'b0;
    din_d         = din_q;
    in_fifo_rd_en = 1'b0;

    // Output space was reserved at batch start, so results are never back-pressured.
    if (core_out_valid) begin
      if (issue_q != ret_q) begin
        wr_d  = 1'b1;
        din_d = core_out_data;
        ret_d = ret_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (enable && !in_fifo_almost_empty && !out_fifo_almost_full) state_d = LOAD;
      LOAD: begin
        in_fifo_rd_en = !in_fifo_empty;
        if (in_fifo_rd_en) begin
          issue_d = issue_q + 1'b1;
          if (issue_q == IW'(PIPELINE_DEPTH - 1)) state_d = WAIT;
        end
      end
      WAIT: if (ret_q == IW'(PIPELINE_DEPTH)) state_d = DONE;
      DONE: begin
        batch_d = batch_q + 1'b1;
        issue_d = '0;
        ret_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      issue_q <= '0;
      ret_q   <= '0;
      batch_q <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      batch_q <= batch_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
    end
  end

  assign core_in_valid  = in_fifo_rd_en;
  assign core_in_first  = in_fifo_rd_en && (issue_q == '0);
  assign core_in_data   = in_fifo_rd_en ? in_fifo_dout : '0;
  assign out_fifo_wr_en = wr_q;
  assign out_fifo_din   = din_q;
  assign busy           = (state_q != IDLE);
  assign batch_cnt      = batch_q;
  assign err_unexpected = err_q;

`ifdef LYRA2_SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] sbusy_q, sstall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbusy_q  <= '0;
      sstall_q <= '0;
    end else begin
      if (state_q != IDLE && sbusy_q != '1) sbusy_q <= sbusy_q + 1'b1;
      if (state_q == LOAD && in_fifo_empty && sstall_q != '1) sstall_q <= sstall_q + 1'b1;
    end
  end

  assign stat_busy_cycles  = sbusy_q;
  assign stat_stall_cycles = sstall_q;
`endif

endmodule
